frontend_pc_gen: RTL and testbench

//  Fetch-PC generator directly upstream of the BTB in the dual-issue frontend: drives the BTB

---
 rtl/frontend_pc_gen.sv | 155 +++++++++++++++
 tb/tb_frontend_pc_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/frontend_pc_gen.sv
// Fetch-PC generator: chooses the next fetch PC (flush > mispredict > BTB taken > sequential),
// drives the I-cache/BTB request and records per-fetch prediction metadata for downstream checks.
module frontend_pc_gen #(
  parameter int unsigned     VLEN      = 64,
  parameter logic [VLEN-1:0] BOOT_ADDR = VLEN'(64'h8000_0000)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [VLEN-1:0]   flush_pc_i,
  input  logic              mispredict_i,
  input  logic [VLEN-1:0]   mispredict_pc_i,
  input  logic              halt_i,
  input  logic [1:0]        btb_valid_i,
  input  logic [2*VLEN-1:0] btb_target_i,
  output logic [VLEN-1:0]   fetch_vaddr_o,
  output logic              fetch_req_o,
  input  logic              fetch_gnt_i,
  output logic              meta_valid_o,
  output logic [VLEN-1:0]   meta_pc_o,
  output logic [1:0]        meta_slot_mask_o,
  output logic              meta_taken_o,
  output logic              meta_taken_slot_o,
  output logic [VLEN-1:0]   meta_target_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [VLEN-1:0]   r_pc;
  logic [VLEN-1:0]   w_pc_next;

  logic              w_fetch_req;
  logic              w_redirect;
  logic              w_accept;
  logic [VLEN-1:0]   w_flush_pc;
  logic [VLEN-1:0]   w_mispredict_pc;
  logic [VLEN-1:0]   w_seq_pc;
  logic [1:0]        w_slot_mask;
  logic [1:0]        w_hit;
  logic [VLEN-1:0]   w_btb_tgt [2];
  logic              w_taken;
  logic              w_taken_slot;
  logic [VLEN-1:0]   w_target;
  logic              w_unused_lsbs;

  logic              r_meta_valid;
  logic [VLEN-1:0]   r_meta_pc;
  logic [1:0]        r_meta_slot_mask;
  logic              r_meta_taken;
  logic              r_meta_taken_slot;
  logic [VLEN-1:0]   r_meta_target;

  // No compressed instructions: the two low address bits are always dropped.
  assign w_flush_pc      = {flush_pc_i[VLEN-1:2], 2'b00};
  assign w_mispredict_pc = {mispredict_pc_i[VLEN-1:2], 2'b00};
  assign w_unused_lsbs   = ^{flush_pc_i[1:0], mispredict_pc_i[1:0],
                             btb_target_i[VLEN+1:VLEN], btb_target_i[1:0]};

  // A fetch starting at pc[2]=1 skips slot 0, so its prediction must be ignored.
  assign w_slot_mask = r_pc[2] ? 2'b10 : 2'b11;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign w_btb_tgt[gi] = {btb_target_i[gi*VLEN+2 +: VLEN-2], 2'b00};
    assign w_hit[gi]     = btb_valid_i[gi] & w_slot_mask[gi];
  end

  assign w_taken      = |w_hit;
  assign w_taken_slot = ~w_hit[0];
  assign w_target     = w_taken ? w_btb_tgt[w_taken_slot] : '0;
  assign w_seq_pc     = {r_pc[VLEN-1:3] + (VLEN-3)'(1), 3'b000};

  assign w_redirect = flush_i | mispredict_i;
  assign w_accept   = fetch_gnt_i & w_fetch_req;

  always_comb begin
    w_pc_next = r_pc;
    if (flush_i) begin
      w_pc_next = w_flush_pc;
    end else if (mispredict_i) begin
      w_pc_next = w_mispredict_pc;
    end else if (w_accept) begin
      w_pc_next = w_taken ? w_target : w_seq_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_BOOT;
      r_pc    <= BOOT_ADDR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // A redirect forces the state to track halt_i, which also covers leaving BOOT.
  always_comb begin
    w_state_next = r_state;
    if (w_redirect) begin
      w_state_next = halt_i ? ST_HALT : ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: w_state_next = ST_RUN;
        ST_RUN:  w_state_next = halt_i ? ST_HALT : ST_RUN;
        ST_HALT: w_state_next = halt_i ? ST_HALT : ST_RUN;
        default: w_state_next = ST_BOOT;
      endcase
    end
  end

  always_comb begin
    w_fetch_req = 1'b0;
    case (r_state)
      ST_RUN:  w_fetch_req = 1'b1;
      default: w_fetch_req = 1'b0;
    endcase
  end

  // Grants in a redirect cycle still reach the I-cache, but their metadata is stale.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta_valid      <= 1'b0;
      r_meta_pc         <= '0;
      r_meta_slot_mask  <= 2'b00;
      r_meta_taken      <= 1'b0;
      r_meta_taken_slot <= 1'b0;
      r_meta_target     <= '0;
    end else begin
      r_meta_valid <= w_accept & ~w_redirect;
      if (w_accept && !w_redirect) begin
        r_meta_pc         <= r_pc;
        r_meta_slot_mask  <= w_slot_mask;
        r_meta_taken      <= w_taken;
        r_meta_taken_slot <= w_taken & w_taken_slot;
        r_meta_target     <= w_target;
      end
    end
  end

  assign fetch_vaddr_o     = r_pc;
  assign fetch_req_o       = w_fetch_req;
  assign meta_valid_o      = r_meta_valid;
  assign meta_pc_o         = r_meta_pc;
  assign meta_slot_mask_o  = r_meta_slot_mask;
  assign meta_taken_o      = r_meta_taken;
  assign meta_taken_slot_o = r_meta_taken_slot;
  assign meta_target_o     = r_meta_target;

endmodule

// File: tb/tb_frontend_pc_gen.sv
// Directed table-driven bench for frontend_pc_gen: one vector per clock, plus a mid-run reset.
module tb_frontend_pc_gen;

  localparam int VLEN = 64;
  localparam int NVEC = 22;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              flush_i = 1'b0;
  logic [VLEN-1:0]   flush_pc_i = '0;
  logic              mispredict_i = 1'b0;
  logic [VLEN-1:0]   mispredict_pc_i = '0;
  logic              halt_i = 1'b0;
  logic [1:0]        btb_valid_i = 2'b00;
  logic [2*VLEN-1:0] btb_target_i = '0;
  logic [VLEN-1:0]   fetch_vaddr_o;
  logic              fetch_req_o;
  logic              fetch_gnt_i = 1'b0;
  logic              meta_valid_o;
  logic [VLEN-1:0]   meta_pc_o;
  logic [1:0]        meta_slot_mask_o;
  logic              meta_taken_o;
  logic              meta_taken_slot_o;
  logic [VLEN-1:0]   meta_target_o;

  int checks = 0;
  int errors = 0;

  frontend_pc_gen #(.VLEN(VLEN), .BOOT_ADDR(64'h8000_0000)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .flush_pc_i        (flush_pc_i),
    .mispredict_i      (mispredict_i),
    .mispredict_pc_i   (mispredict_pc_i),
    .halt_i            (halt_i),
    .btb_valid_i       (btb_valid_i),
    .btb_target_i      (btb_target_i),
    .fetch_vaddr_o     (fetch_vaddr_o),
    .fetch_req_o       (fetch_req_o),
    .fetch_gnt_i       (fetch_gnt_i),
    .meta_valid_o      (meta_valid_o),
    .meta_pc_o         (meta_pc_o),
    .meta_slot_mask_o  (meta_slot_mask_o),
    .meta_taken_o      (meta_taken_o),
    .meta_taken_slot_o (meta_taken_slot_o),
    .meta_target_o     (meta_target_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic            flush;
    logic [63:0]     flush_pc;
    logic            mp;
    logic [63:0]     mp_pc;
    logic            halt;
    logic [1:0]      bv;
    logic [63:0]     t0;
    logic [63:0]     t1;
    logic            gnt;
    logic [63:0]     e_vaddr;
    logic            e_req;
    logic            e_mv;
    logic [63:0]     e_mpc;
    logic [1:0]      e_mask;
    logic            e_taken;
    logic            e_slot;
    logic [63:0]     e_tgt;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " vaddr"}, fetch_vaddr_o, v.e_vaddr);
    chk({tag, " req"}, 64'(fetch_req_o), 64'(v.e_req));
    chk({tag, " meta_valid"}, 64'(meta_valid_o), 64'(v.e_mv));
    chk({tag, " meta_pc"}, meta_pc_o, v.e_mpc);
    chk({tag, " meta_mask"}, 64'(meta_slot_mask_o), 64'(v.e_mask));
    chk({tag, " meta_taken"}, 64'(meta_taken_o), 64'(v.e_taken));
    chk({tag, " meta_slot"}, 64'(meta_taken_slot_o), 64'(v.e_slot));
    chk({tag, " meta_target"}, meta_target_o, v.e_tgt);
  endtask

  initial begin
    //            flush flush_pc             mp   mp_pc                halt bv     t0                   t1                   gnt   vaddr                req  mv   meta_pc              mask   tk   sl   target
    vecs[0]  = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b1, 64'h8000_0000,       1'b1, 1'b0, 64'h0,               2'b00, 1'b0, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b1, 64'h8000_0008,       1'b1, 1'b1, 64'h8000_0000,       2'b11, 1'b0, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b1, 64'h8000_0010,       1'b1, 1'b1, 64'h8000_0008,       2'b11, 1'b0, 1'b0, 64'h0};
    // mispredict into slot 1 while granted: metadata for the granted fetch is dropped
    vecs[3]  = '{1'b0, 64'h0,                1'b1, 64'h8000_0004,        1'b0, 2'b00, 64'h0,               64'h0,               1'b1, 64'h8000_0004,       1'b1, 1'b0, 64'h8000_0008,       2'b11, 1'b0, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b01, 64'hDEAD_0000,       64'h0,               1'b1, 64'h8000_0008,       1'b1, 1'b1, 64'h8000_0004,       2'b10, 1'b0, 1'b0, 64'h0};
    vecs[5]  = '{1'b1, 64'h8000_0000,        1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b0, 64'h8000_0000,       1'b1, 1'b0, 64'h8000_0004,       2'b10, 1'b0, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b11, 64'h9000_0000,       64'hA000_0000,       1'b1, 64'h9000_0000,       1'b1, 1'b1, 64'h8000_0000,       2'b11, 1'b1, 1'b0, 64'h9000_0000};
    vecs[7]  = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b10, 64'h0,               64'hA000_0006,       1'b1, 64'hA000_0004,       1'b1, 1'b1, 64'h9000_0000,       2'b11, 1'b1, 1'b1, 64'hA000_0004};
    vecs[8]  = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b10, 64'h0,               64'hB000_0000,       1'b1, 64'hB000_0000,       1'b1, 1'b1, 64'hA000_0004,       2'b10, 1'b1, 1'b1, 64'hB000_0000};
    // three cycles without grant: address and metadata hold, valid drops
    vecs[9]  = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b0, 64'hB000_0000,       1'b1, 1'b0, 64'hA000_0004,       2'b10, 1'b1, 1'b1, 64'hB000_0000};
    vecs[10] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b0, 64'hB000_0000,       1'b1, 1'b0, 64'hA000_0004,       2'b10, 1'b1, 1'b1, 64'hB000_0000};
    vecs[11] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b0, 64'hB000_0000,       1'b1, 1'b0, 64'hA000_0004,       2'b10, 1'b1, 1'b1, 64'hB000_0000};
    vecs[12] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b1, 64'hB000_0008,       1'b1, 1'b1, 64'hB000_0000,       2'b11, 1'b0, 1'b0, 64'h0};
    vecs[13] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b0, 64'hB000_0008,       1'b1, 1'b0, 64'hB000_0000,       2'b11, 1'b0, 1'b0, 64'h0};
    // flush beats mispredict beats BTB
    vecs[14] = '{1'b1, 64'h8000_1000,        1'b1, 64'h8000_2000,        1'b0, 2'b01, 64'hC000_0000,       64'h0,               1'b1, 64'h8000_1000,       1'b1, 1'b0, 64'hB000_0000,       2'b11, 1'b0, 1'b0, 64'h0};
    // halt rises while granted: that fetch still completes
    vecs[15] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b1, 2'b00, 64'h0,               64'h0,               1'b1, 64'h8000_1008,       1'b0, 1'b1, 64'h8000_1000,       2'b11, 1'b0, 1'b0, 64'h0};
    vecs[16] = '{1'b0, 64'h0,                1'b1, 64'h8000_3003,        1'b1, 2'b00, 64'h0,               64'h0,               1'b1, 64'h8000_3000,       1'b0, 1'b0, 64'h8000_1000,       2'b11, 1'b0, 1'b0, 64'h0};
    vecs[17] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b1, 2'b00, 64'h0,               64'h0,               1'b1, 64'h8000_3000,       1'b0, 1'b0, 64'h8000_1000,       2'b11, 1'b0, 1'b0, 64'h0};
    vecs[18] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b0, 64'h8000_3000,       1'b1, 1'b0, 64'h8000_1000,       2'b11, 1'b0, 1'b0, 64'h0};
    vecs[19] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b1, 64'h8000_3008,       1'b1, 1'b1, 64'h8000_3000,       2'b11, 1'b0, 1'b0, 64'h0};
    // sequential wrap at the top of the address space
    vecs[20] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 64'h0,             1'b0, 2'b00, 64'h0,               64'h0,               1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0, 64'h8000_3000,     2'b11, 1'b0, 1'b0, 64'h0};
    vecs[21] = '{1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 2'b00, 64'h0,               64'h0,               1'b1, 64'h0,               1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2'b11, 1'b0, 1'b0, 64'h0};

    #3 rst_ni = 1'b0;
    fetch_gnt_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset vaddr", fetch_vaddr_o, 64'h8000_0000);
    chk("reset req", 64'(fetch_req_o), 64'h0);
    chk("reset meta_valid", 64'(meta_valid_o), 64'h0);
    chk("reset meta_pc", meta_pc_o, 64'h0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_i);
      rst_ni          = 1'b1;
      flush_i         = vecs[i].flush;
      flush_pc_i      = vecs[i].flush_pc;
      mispredict_i    = vecs[i].mp;
      mispredict_pc_i = vecs[i].mp_pc;
      halt_i          = vecs[i].halt;
      btb_valid_i     = vecs[i].bv;
      btb_target_i    = {vecs[i].t1, vecs[i].t0};
      fetch_gnt_i     = vecs[i].gnt;
      @(posedge clk_i);
      #1;
      chk_all($sformatf("row%0d", i), vecs[i]);
    end

    // Asynchronous reset between clock edges, then BOOT for one cycle again.
    @(negedge clk_i);
    flush_i = 1'b0; mispredict_i = 1'b0; halt_i = 1'b0;
    btb_valid_i = 2'b00; fetch_gnt_i = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset vaddr", fetch_vaddr_o, 64'h8000_0000);
    chk("midreset req", 64'(fetch_req_o), 64'h0);
    chk("midreset meta_valid", 64'(meta_valid_o), 64'h0);
    chk("midreset meta_pc", meta_pc_o, 64'h0);
    chk("midreset meta_mask", 64'(meta_slot_mask_o), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("boot req low", 64'(fetch_req_o), 64'h0);
    @(posedge clk_i);
    #1;
    chk("boot req rises", 64'(fetch_req_o), 64'h1);
    chk("boot vaddr", fetch_vaddr_o, 64'h8000_0000);
    @(posedge clk_i);
    #1;
    chk("boot first advance", fetch_vaddr_o, 64'h8000_0008);
    chk("boot first meta", 64'(meta_valid_o), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
